// File: rtl/mcpu_vram_bridge.sv
// mcpu_vram_bridge: posts CPU VRAM stores into a small FIFO
// and retires them into the GPU VRAM port only during blanking.
module mcpu_vram_bridge #(
  parameter int ADDR_WIDTH  = 13,
  parameter int VDATA_WIDTH = 8,
  parameter int DEPTH_LOG2  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_we,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic [VDATA_WIDTH-1:0] cpu_data,
  input  logic                   flush,
  input  logic                   ovf_clr,
  input  logic                   display_on,
  output logic [ADDR_WIDTH-1:0]  vram_addr,
  output logic [VDATA_WIDTH-1:0] vram_data,
  output logic                   vram_we,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH_LOG2:0]    count,
  output logic                   overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [ADDR_WIDTH-1:0]  addr_mem [DEPTH];
  logic [VDATA_WIDTH-1:0] data_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] tail_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  ovf_q;

  logic pop;
  logic tail_hit;
  logic tail_popping;
  logic coalesce;
  logic push;
  logic drop;

  // count never exceeds DEPTH, so the MSB alone marks full
  assign empty = (cnt == '0);
  assign full  = cnt[DEPTH_LOG2];
  assign count = cnt;
  assign overflow = ovf_q;

  assign tail_ptr = wr_ptr - 1'b1;

  // retire is held off while reset is asserted so a pending
  // entry cannot leak out in the cycle that discards it
  assign vram_we = reset && !empty && !display_on && !flush;
  assign pop     = vram_we;

  assign tail_hit     = (addr_mem[tail_ptr] == cpu_addr);
  assign tail_popping = pop && (tail_ptr == rd_ptr);

  assign coalesce = cpu_we && !flush && !empty &&
                    tail_hit && !tail_popping;
  assign push     = cpu_we && !flush && !coalesce && !full;
  assign drop     = cpu_we && !flush && !coalesce && full;

  // head entry, forced to zero when nothing is queued
  always_comb begin
    vram_addr = '0;
    vram_data = '0;
    if (!empty) begin
      vram_addr = addr_mem[rd_ptr];
      vram_data = data_mem[rd_ptr];
    end
  end

  // entry storage: new push at wr_ptr or data merge into tail
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= cpu_addr;
      data_mem[wr_ptr] <= cpu_data;
    end else if (coalesce) begin
      data_mem[tail_ptr] <= cpu_data;
    end
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // sticky drop flag; a drop beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!reset)
      ovf_q <= 1'b0;
    else if (drop)
      ovf_q <= 1'b1;
    else if (ovf_clr)
      ovf_q <= 1'b0;
  end

endmodule

// File: tb/tb_mcpu_vram_bridge.sv
// tb_mcpu_vram_bridge: directed and random stimulus against
// a queue-based model of the write-posting bridge.
module tb_mcpu_vram_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        flush;
  logic        ovf_clr;
  logic        display_on;
  logic [12:0] vram_addr;
  logic [7:0]  vram_data;
  logic        vram_we;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;

  int n_chk  = 0;
  int n_fail = 0;

  mcpu_vram_bridge dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .flush      (flush),
    .ovf_clr    (ovf_clr),
    .display_on (display_on),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .vram_we    (vram_we),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] a;
    logic [7:0]  d;
  } ent_t;

  ent_t q[$];
  bit   m_ovf   = 1'b0;
  bit   m_valid = 1'b0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit m_we();
    return reset && q.size() > 0 && !display_on && !flush;
  endfunction

  // model: advance the queue on each rising edge
  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      m_ovf   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (flush) begin
        q.delete();
        if (ovf_clr) m_ovf = 1'b0;
      end else begin
        int  sz;
        bit  pp;
        bit  co;
        bit  dr;
        sz = q.size();
        pp = m_we();
        co = cpu_we && sz > 0 && q[sz-1].a == cpu_addr &&
             !(pp && sz == 1);
        dr = 1'b0;
        if (co) q[sz-1].d = cpu_data;
        if (pp) void'(q.pop_front());
        if (cpu_we && !co) begin
          if (sz < 8) begin
            ent_t e;
            e.a = cpu_addr;
            e.d = cpu_data;
            q.push_back(e);
          end else begin
            dr = 1'b1;
          end
        end
        if (dr) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
      end
    end
  end

  // compare: every falling edge once the model is known
  always @(negedge clk) begin
    if (m_valid) begin
      chk("vram_we", vram_we, m_we());
      chk("count", count, q.size());
      chk("empty", empty, q.size() == 0);
      chk("full", full, q.size() == 8);
      chk("overflow", overflow, m_ovf);
      chk("vram_addr", vram_addr, q.size() ? q[0].a : 0);
      chk("vram_data", vram_data, q.size() ? q[0].d : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(bit we, logic [12:0] a, logic [7:0] d,
                     bit disp, bit fl = 0, bit oc = 0);
    cpu_we     = we;
    cpu_addr   = a;
    cpu_data   = d;
    display_on = disp;
    flush      = fl;
    ovf_clr    = oc;
  endtask

  initial begin
    reset = 1'b0;
    set(0, 0, 0, 1);
    tick();
    tick();
    reset = 1'b1;
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_we", vram_we, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_addr", vram_addr, 0);

    tick();
    set(1, 13'h0010, 8'hAA, 0);
    tick();
    set(0, 0, 0, 0);
    #2;
    chk("drain_we", vram_we, 1);
    chk("drain_addr", vram_addr, 13'h0010);
    chk("drain_data", vram_data, 8'hAA);
    tick();
    #2;
    chk("drain_empty", empty, 1);

    tick();
    for (int i = 0; i < 3; i++) begin
      set(1, 13'h0020 + 13'(i), 8'h50 + 8'(i), 1);
      tick();
    end
    set(0, 0, 0, 1);
    #2;
    chk("hold_count", count, 3);
    chk("hold_we", vram_we, 0);
    tick();
    set(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("hold_drain_we", vram_we, 1);
      chk("hold_drain_addr", vram_addr, 32'h20 + i);
      tick();
    end
    #2;
    chk("hold_done", empty, 1);

    tick();
    for (int i = 0; i < 9; i++) begin
      set(1, 13'h0030 + 13'(i), 8'h90 + 8'(i), 1);
      tick();
    end
    set(0, 0, 0, 1);
    #2;
    chk("full_flag", full, 1);
    chk("full_count", count, 8);
    chk("full_ovf", overflow, 1);
    tick();
    set(0, 0, 0, 1, 0, 1);
    tick();
    set(0, 0, 0, 1);
    #2;
    chk("ovf_clr", overflow, 0);
    tick();
    set(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("full_drain_addr", vram_addr, 32'h30 + i);
      tick();
    end
    #2;
    chk("ninth_lost", empty, 1);

    tick();
    set(1, 13'h0100, 8'h11, 1);
    tick();
    set(1, 13'h0100, 8'h22, 1);
    tick();
    set(0, 0, 0, 1);
    #2;
    chk("coal_count", count, 1);
    tick();
    set(0, 0, 0, 0);
    #2;
    chk("coal_we", vram_we, 1);
    chk("coal_data", vram_data, 8'h22);
    tick();
    #2;
    chk("coal_single", empty, 1);

    tick();
    for (int i = 0; i < 20; i++) begin
      set(1, 13'h0200 + 13'(i), 8'($urandom), 0);
      tick();
    end
    set(0, 0, 0, 0);
    tick();
    tick();

    for (int i = 0; i < 4; i++) begin
      set(1, 13'h0040 + 13'(i), 8'h70 + 8'(i), 1);
      tick();
    end
    set(1, 13'h0050, 8'h55, 0, 1);
    #2;
    chk("flush_we", vram_we, 0);
    tick();
    set(0, 0, 0, 1);
    #2;
    chk("flush_count", count, 0);
    chk("flush_ovf", overflow, 0);
    tick();

    for (int i = 0; i < 3; i++) begin
      set(1, 13'h0060 + 13'(i), 8'h33, 1);
      tick();
    end
    reset = 1'b0;
    set(0, 0, 0, 0);
    #2;
    chk("rst_mid_we", vram_we, 0);
    tick();
    reset = 1'b1;
    #2;
    chk("rst_mid_empty", empty, 1);
    tick();

    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) != 0);
      set($urandom_range(0, 2) != 0,
          13'($urandom_range(0, 5)),
          8'($urandom),
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 31) == 0,
          $urandom_range(0, 15) == 0);
      tick();
    end
    reset = 1'b1;
    set(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
